// File: rtl/pc_seq_pkg.sv
// Shared types and default sizes for the program-counter sequencer.
package pc_seq_pkg;

  // Sequencer states; the top exposes the current one on a debug output.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int PC_W_DEF    = 10;
  localparam int LUT_AW_DEF  = 9;
  localparam int CNT_W_DEF   = 16;
  localparam int BOOT_PC_DEF = 0;

endpackage

// File: rtl/pc_branch_sequencer.sv
// Program-counter sequencer: owns the PC, drives the branch-target LUT
// address, and reports halt/fault completion plus a retired-instruction count.
//
// Handshake: Start is a one-cycle pulse honoured only in IDLE or HALTED; it
// moves the sequencer to RUN on the next edge and clears Done/Fault/RetireCnt.
// Running is high while in RUN. On leaving RUN exactly one of Done (HaltReq)
// or Fault (unmapped branch or PC overflow) is raised and held until the next
// accepted Start. Start while running is ignored.
module pc_branch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int LUT_AW  = LUT_AW_DEF,
  parameter int BOOT_PC = BOOT_PC_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Stall,
  input  logic              BranchEn,
  input  logic              BranchTaken,
  input  logic [LUT_AW-1:0] BranchIdx,
  input  logic              HaltReq,
  output logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutTarget,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic              Fault,
  output logic [CNT_W-1:0]  RetireCnt,
  output state_t            StateDbg
);

  localparam logic [PC_W-1:0] BOOT = PC_W'(BOOT_PC);
  localparam logic [PC_W-1:0] PC_MAX = '1;

  state_t           state, state_n;
  logic [PC_W-1:0]  pc_n;
  logic             done_n, fault_n;
  logic [CNT_W-1:0] cnt_n, cnt_inc;

  // The LUT is addressed straight from the instruction field, zero latency.
  assign LutAddr  = BranchIdx;
  assign Running  = (state == RUN);
  assign StateDbg = state;
  assign cnt_inc  = (RetireCnt == '1) ? RetireCnt : RetireCnt + 1'b1;

  // Next-state / next-PC selection; LutTarget is only looked at on a taken branch.
  always_comb begin
    state_n = state;
    pc_n    = PC;
    done_n  = Done;
    fault_n = Fault;
    cnt_n   = RetireCnt;
    case (state)
      RUN: begin
        if (Stall) begin
          // hold everything
        end else if (HaltReq) begin
          state_n = HALTED;
          done_n  = 1'b1;
          cnt_n   = cnt_inc;
        end else if (BranchEn && BranchTaken) begin
          if (LutTarget == '0) begin
            state_n = HALTED;
            fault_n = 1'b1;
          end else begin
            pc_n  = LutTarget;
            cnt_n = cnt_inc;
          end
        end else if (PC == PC_MAX) begin
          state_n = HALTED;
          fault_n = 1'b1;
        end else begin
          pc_n  = PC + 1'b1;
          cnt_n = cnt_inc;
        end
      end
      default: begin
        if (Start) begin
          state_n = RUN;
          pc_n    = BOOT;
          done_n  = 1'b0;
          fault_n = 1'b0;
          cnt_n   = '0;
        end
      end
    endcase
  end

  // State, PC, completion flags and retire counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      PC        <= BOOT;
      Done      <= 1'b0;
      Fault     <= 1'b0;
      RetireCnt <= '0;
    end else begin
      state     <= state_n;
      PC        <= pc_n;
      Done      <= done_n;
      Fault     <= fault_n;
      RetireCnt <= cnt_n;
    end
  end

endmodule
